// File: rtl/led_sequence_if.sv
// rtl/led_sequence_if.sv - divisor input and LED/divided-clock outputs of the LED chaser
interface led_sequence_if #(
  parameter int NUM_LEDS  = 10,
  parameter int DIV_WIDTH = 32
);
  logic [DIV_WIDTH-1:0] divisor;
  logic                 div_clk;
  logic                 div_clk_n;
  logic [NUM_LEDS-1:0]  led_out;

  modport master (
    output divisor,
    input  div_clk,
    input  div_clk_n,
    input  led_out
  );

  modport slave (
    input  divisor,
    output div_clk,
    output div_clk_n,
    output led_out
  );
endinterface

// File: rtl/led_sequence.sv
// rtl/led_sequence.sv - bouncing one-hot LED chaser driven by a programmable clock divider
module led_sequence #(
  parameter int NUM_LEDS  = 10,
  parameter int DIV_WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  led_sequence_if.slave bus
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0]  LED_ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] eff_div;
  logic                 terminal;
  logic                 adv;
  logic                 div_clk_q;
  logic                 div_clk_n_q;
  logic [NUM_LEDS-1:0]  led_q;
  logic                 led_legal;
  dir_t                 dir;

  // Terminal count and the advance strobe; >= lets a shrunken divisor end the half-period at once
  always_comb begin
    eff_div   = (bus.divisor == '0) ? DIV_ONE : bus.divisor;
    terminal  = (cnt >= (eff_div - DIV_ONE));
    adv       = terminal && !div_clk_q;
    led_legal = (led_q != '0) && ((led_q & (led_q - LED_ONE)) == '0);
  end

  // Divide counter and the registered divided clock pair
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      div_clk_q   <= 1'b0;
      div_clk_n_q <= 1'b1;
    end else if (terminal) begin
      cnt         <= '0;
      div_clk_q   <= ~div_clk_q;
      div_clk_n_q <= div_clk_q;
    end else begin
      cnt <= cnt + DIV_ONE;
    end
  end

  // Bounce sequencer, stepping only on the cycle div_clk rises; illegal patterns recover to bit 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q <= LED_ONE;
      dir   <= DIR_UP;
    end else if (adv) begin
      if (!led_legal) begin
        led_q <= LED_ONE;
        dir   <= DIR_UP;
      end else begin
        case (dir)
          DIR_UP: begin
            if (led_q[NUM_LEDS-1]) begin
              dir   <= DIR_DOWN;
              led_q <= led_q >> 1;
            end else begin
              led_q <= led_q << 1;
            end
          end
          default: begin
            if (led_q[0]) begin
              dir   <= DIR_UP;
              led_q <= led_q << 1;
            end else begin
              led_q <= led_q >> 1;
            end
          end
        endcase
      end
    end
  end

  assign bus.div_clk   = div_clk_q;
  assign bus.div_clk_n = div_clk_n_q;
  assign bus.led_out   = led_q;

endmodule

// File: tb/tb_led_sequence.sv
// tb/tb_led_sequence.sv - directed and randomized checks of led_sequence against a sweep-position model
module tb_led_sequence;
  localparam int N     = 10;
  localparam int W     = 32;
  localparam int SWEEP = 2 * (N - 1);

  logic clock = 1'b0;
  logic reset = 1'b1;

  led_sequence_if #(.NUM_LEDS(N), .DIV_WIDTH(W)) bus ();

  led_sequence #(.NUM_LEDS(N), .DIV_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: cycles spent in the current half-period, divided clock level, position along the sweep
  int m_half = 0;
  bit m_dc   = 1'b0;
  int m_pos  = 0;

  function automatic logic [N-1:0] model_led(int pos);
    logic [N-1:0] one;
    int idx;
    one = 1;
    idx = (pos < N) ? pos : SWEEP - pos;
    return one << idx;
  endfunction

  task automatic model_reset();
    m_half = 0;
    m_dc   = 1'b0;
    m_pos  = 0;
  endtask

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    check_eq({tag, "_led"}, 32'(bus.led_out), 32'(model_led(m_pos)));
    check_eq({tag, "_div_clk"}, 32'(bus.div_clk), 32'(m_dc));
    check_eq({tag, "_div_clk_n"}, 32'(bus.div_clk_n), 32'(!m_dc));
  endtask

  task automatic tick(string tag);
    longint eff;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      eff = (bus.divisor == 0) ? 1 : longint'(bus.divisor);
      m_half++;
      if (m_half >= eff) begin
        m_half = 0;
        m_dc   = !m_dc;
        if (m_dc) m_pos = (m_pos + 1) % SWEEP;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic restart(logic [W-1:0] div);
    reset = 1'b1;
    model_reset();
    bus.divisor = div;
    tick("restart");
    tick("restart");
    reset = 1'b0;
  endtask

  initial begin
    int n;
    logic prev_dc;
    bus.divisor = 2;
    model_reset();

    // Reset held: outputs frozen at reset values
    for (int i = 0; i < 5; i++) tick("reset_hold");
    reset = 1'b0;

    // divisor=2: rises on edges 2, 6, 10
    for (int i = 1; i <= 12; i++) begin
      tick("div2");
      if (i == 2)  begin check_eq("div2_e2_led", 32'(bus.led_out), 32'h002); check_eq("div2_e2_clk", 32'(bus.div_clk), 32'h1); end
      if (i == 6)  check_eq("div2_e6_led", 32'(bus.led_out), 32'h004);
      if (i == 10) check_eq("div2_e10_led", 32'(bus.led_out), 32'h008);
    end

    // divisor=1 and divisor=0: full bounce sweep
    for (int d = 1; d >= 0; d--) begin
      restart(W'(d));
      for (int i = 1; i <= 40; i++) begin
        tick("fast");
        if (i == 18) check_eq("sweep_adv9", 32'(bus.led_out), 32'h200);
        if (i == 20) check_eq("sweep_adv10", 32'(bus.led_out), 32'h100);
        if (i == 36) check_eq("sweep_adv18", 32'(bus.led_out), 32'h001);
        if (i == 38) check_eq("sweep_adv19", 32'(bus.led_out), 32'h002);
      end
    end

    // divisor=8 reduced to 2 once the count has reached 5
    restart(8);
    for (int i = 0; i < 5; i++) tick("div8");
    bus.divisor = 2;
    tick("shrink");
    check_eq("shrink_toggle", 32'(bus.div_clk), 32'h1);
    check_eq("shrink_led", 32'(bus.led_out), 32'h002);
    tick("shrink");
    tick("shrink");
    check_eq("shrink_fall", 32'(bus.div_clk), 32'h0);
    tick("shrink");
    tick("shrink");
    check_eq("shrink_rise_led", 32'(bus.led_out), 32'h004);
    for (int i = 0; i < 8; i++) tick("shrink");

    // Randomized divisor changes
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus.divisor = W'($urandom_range(0, 9));
      tick("random");
    end

    // Asynchronous reset between edges while 0x040 is lit
    restart(1);
    n = 0;
    while (model_led(m_pos) != 10'h040 && n < 100) begin
      tick("seek");
      n++;
    end
    check_eq("seek_0x040", 32'(bus.led_out), 32'h040);
    #2;
    prev_dc = bus.div_clk;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("async_reset");
    check_eq("async_led", 32'(bus.led_out), 32'h001);
    tick("async_hold");
    reset = 1'b0;
    tick("after_async");
    check_eq("after_async_led", 32'(bus.led_out), 32'h002);
    for (int i = 0; i < 20; i++) tick("after_async");
    if (prev_dc) n = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/led_sequence.md
# led_sequence

Free-running LED chaser with an integrated 32-bit programmable clock divider. A single lit LED bounces across a 10-LED bank, bit 0 to bit 9 and back. It advances once per period of the divided clock. The block drives the board LED bank directly and also exports the divided clock and its complement for neighbouring logic.

## Interface
- NUM_LEDS, default 10: width of the LED bank; minimum 2.
- DIV_WIDTH, default 32: width of the divisor and of the internal divide counter.
- clock  input  1  system clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- divisor  input  DIV_WIDTH  half-period of the divided clock, in clock cycles; sampled every cycle.
- div_clk  output  1  divided clock, registered.
- div_clk_n  output  1  always the inverse of div_clk, registered.
- led_out  output  NUM_LEDS  one-hot LED pattern, registered.

## Operation
- Effective divisor:
  - eff_div = divisor when divisor ≠ 0.
  - eff_div = 1 when divisor = 0.
- Divide counter (cnt, DIV_WIDTH bits):
  - If cnt ≥ eff_div−1: on the next clock edge cnt ← 0 and div_clk toggles.
  - Otherwise cnt ← cnt+1.
  - Using ≥ rather than = means a divisor reduced below the current count takes effect at once, with no wrap through 2^32.
- The divided clock has a period of 2·eff_div clock cycles at 50% duty.
- The sequencer is not clocked by div_clk. It uses an internal one-cycle enable, adv, asserted in the cycle where div_clk is about to toggle 0→1. There is a single clock domain.
- Sequencer state:
  - led_out, one-hot.
  - dir: 0 = shifting toward the MSB, 1 = shifting toward the LSB.
- On each adv:
  - dir=0, led_out[NUM_LEDS−1] not set: shift left by 1.
  - dir=0, led_out[NUM_LEDS−1] set: dir←1 and shift right by 1.
  - dir=1, led_out[0] not set: shift right by 1.
  - dir=1, led_out[0] set: dir←0 and shift left by 1.
- Full sweep: 2·(NUM_LEDS−1) = 18 advances, returning to 0x001.
- led_out is always exactly one-hot. If an illegal state is ever detected (zero or multiple bits set), the next adv loads 0x001 with dir=0.
- Reset values, applied asynchronously while reset=1:
  - cnt=0, div_clk=0, div_clk_n=1.
  - led_out=10'b00_0000_0001, dir=0.
- Outputs hold their reset values for as long as reset remains high.

## Timing
- All outputs are registered; there is no combinational path from divisor to any output.
- First rising edge of div_clk: clock edge eff_div after reset release. led_out changes on that same edge, first to 0x002.
- Thereafter:
  - div_clk rises every 2·eff_div edges.
  - led_out changes exactly on each div_clk rising edge.
  - led_out does not change on div_clk falling edges.
- divisor=1: div_clk toggles every clock edge and the LED advances every 2 cycles.
- divisor=2: div_clk toggles every 2 edges and the LED advances every 4 cycles.
- Divisor change mid-count: takes effect on the next compare (following edge). The current half-period ends at max(new eff_div, cnt+1) cycles.
- Reset asserted mid-operation: outputs go to their reset values without waiting for a clock edge. After release, counting restarts from cnt=0.
- Simultaneous reset release and clock edge: reset dominates on that edge; counting begins on the next edge.

## Test plan
- Hold reset=1 for 5 clocks with divisor=2 → div_clk=0, div_clk_n=1, led_out=0x001 throughout, with no toggling.
- Release reset with divisor=2 → div_clk rises on edges 2, 6, 10, …; led_out steps 0x002, 0x004, 0x008 on edges 2, 6, 10.
- divisor=1 for 40 clocks → div_clk toggles every edge. led_out reaches 0x200 after 9 advances, then returns 0x100, 0x080, … to 0x001 at advance 18, then 0x002 at advance 19.
- divisor=0 → behaviour identical to divisor=1.
- divisor=8 while cnt=5, then divisor changed to 2 → next div_clk toggle on the following edge; steady 4-cycle period after that.
- Assert reset asynchronously between clock edges while led_out=0x040 → led_out=0x001 and div_clk=0 immediately, before the next clock edge; sequence restarts from 0x001 after release.
